// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer. Turns the EX/MEM load/store into a
// request/grant/response bus transaction, builds byte enables and
// lane-replicated store data, stalls the pipeline until the access
// finishes, and reports misaligned accesses and bus timeouts.
module mem_access_ctrl #(
    parameter int Width   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_MEM,
    input  logic             ld_MEM,
    input  logic             st_en_MEM,
    input  logic             SB_MEM,
    input  logic             SH_MEM,
    input  logic [Width-1:0] alu_MEM,
    input  logic [Width-1:0] outmux_fb_MEM,
    output logic             req_o,
    output logic             we_o,
    output logic [Width-1:0] addr_o,
    output logic [Width-1:0] wdata_o,
    output logic [3:0]       be_o,
    input  logic             gnt_i,
    input  logic             rvalid_i,
    input  logic [Width-1:0] rdata_i,
    output logic [Width-1:0] ld_data_o,
    output logic             stall_o,
    output logic             misaligned_o,
    output logic             bus_err_o
);

    localparam int              CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CntW-1:0]   cnt_q;
    logic              mem_op;
    logic              misaligned;
    logic              timeout_hit;
    logic [3:0]        be_d;
    logic [Width-1:0]  wdata_d;
    logic              mis_q;
    logic              err_q;

    assign mem_op       = valid_MEM & (ld_MEM | st_en_MEM);
    assign stall_o      = mem_op & (state_q != DONE);
    assign misaligned_o = mis_q;
    assign bus_err_o    = err_q;

    // Access-size decode: lane enables, replicated store data, alignment
    always_comb begin
        be_d       = 4'b1111;
        wdata_d    = outmux_fb_MEM;
        misaligned = 1'b0;
        if (SB_MEM) begin
            be_d    = 4'b0001 << alu_MEM[1:0];
            wdata_d = {(Width/8){outmux_fb_MEM[7:0]}};
        end else if (SH_MEM) begin
            be_d       = 4'b0011 << {alu_MEM[1], 1'b0};
            wdata_d    = {(Width/16){outmux_fb_MEM[15:0]}};
            misaligned = alu_MEM[0];
        end else begin
            misaligned = |alu_MEM[1:0];
        end
    end

    // Next-state logic; a timeout fires on the TIMEOUT-th REQ/WAIT cycle
    // only if that cycle brings no grant/response
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                if (gnt_i) begin
                    state_d = we_o ? DONE : WAIT;
                end else if (cnt_q >= CntLast) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end
            WAIT: begin
                if (rvalid_i) begin
                    state_d = DONE;
                end else if (cnt_q >= CntLast) begin
                    timeout_hit = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers: state, registered request, timeout counter, status pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_o   <= 1'b0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_o   <= (state_d == REQ);
            mis_q   <= (state_q == IDLE) && mem_op && misaligned;
            err_q   <= timeout_hit;
            if (state_q == IDLE) begin
                cnt_q <= '0;
            end else if ((state_q == REQ || state_q == WAIT) && cnt_q != CntMax) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Bus-side datapath: capture the request on launch, capture read data on response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_o      <= 1'b0;
            addr_o    <= '0;
            wdata_o   <= '0;
            be_o      <= '0;
            ld_data_o <= '0;
        end else begin
            if (state_q == IDLE && mem_op && !misaligned) begin
                we_o    <= st_en_MEM;
                addr_o  <= {alu_MEM[Width-1:2], 2'b00};
                wdata_o <= wdata_d;
                be_o    <= be_d;
            end
            if (state_q == WAIT && rvalid_i) begin
                ld_data_o <= rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// load/store traffic, compared against a transaction-level model.
module tb_mem_access_ctrl;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_MEM, ld_MEM, st_en_MEM, SB_MEM, SH_MEM;
    logic [31:0] alu_MEM, outmux_fb_MEM;
    logic        req_o, we_o;
    logic [31:0] addr_o, wdata_o;
    logic [3:0]  be_o;
    logic        gnt_i, rvalid_i;
    logic [31:0] rdata_i, ld_data_o;
    logic        stall_o, misaligned_o, bus_err_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_ld = '0;

    always #5 clk_i = ~clk_i;

    mem_access_ctrl #(.Width(32), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .valid_MEM(valid_MEM), .ld_MEM(ld_MEM), .st_en_MEM(st_en_MEM),
        .SB_MEM(SB_MEM), .SH_MEM(SH_MEM),
        .alu_MEM(alu_MEM), .outmux_fb_MEM(outmux_fb_MEM),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
        .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .ld_data_o(ld_data_o), .stall_o(stall_o),
        .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
    );

    typedef struct {
        bit          mis;
        bit          err;
        bit          we;
        bit          upd;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        int          reqs;
    } exp_t;

    // Transaction-level expectation: g = REQ cycles without grant before the grant,
    // r = WAIT cycles without response before rvalid
    function automatic exp_t model(input bit v, input bit ld, input bit st, input bit sb,
                                   input bit sh, input logic [31:0] alu, input logic [31:0] data,
                                   input int g, input int r);
        exp_t e;
        int size, off, base, fin, lim;
        size    = sb ? 1 : (sh ? 2 : 4);
        off     = int'(alu % 4);
        base    = off - int'(alu % size);
        e.mis   = (alu % size) != 0;
        e.be    = 4'(((1 << size) - 1) << base);
        e.addr  = alu - (alu % 4);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = data[8*(i % size) +: 8];
        e.we    = st;
        e.err   = 1'b0;
        e.upd   = 1'b0;
        e.stall = 0;
        e.reqs  = 0;
        if (!(v && (ld || st))) begin
            e.mis = 1'b0;
        end else if (e.mis) begin
            e.stall = 1;
        end else if (g >= TO) begin
            e.err = 1'b1; e.stall = 1 + TO; e.reqs = TO;
        end else if (st) begin
            e.stall = g + 2; e.reqs = g + 1;
        end else begin
            e.reqs = g + 1;
            fin = g + 2 + r;
            lim = (TO > g + 2) ? TO : g + 2;
            if (fin <= lim) begin
                e.upd = 1'b1; e.stall = 1 + fin;
            end else begin
                e.err = 1'b1; e.stall = 1 + lim;
            end
        end
        return e;
    endfunction

    // Runs one instruction through MEM, acting as the bus slave; entered and left
    // just after a rising edge so consecutive calls are back-to-back
    task automatic do_access(input string tag, input bit v, input bit ld, input bit st,
                             input bit sb, input bit sh, input logic [31:0] alu,
                             input logic [31:0] data, input int g, input int r,
                             input logic [31:0] rd);
        exp_t e;
        int nstall = 0, nreq = 0, nmis = 0, nerr = 0, wait_seen = 0;
        bit granted = 0, done = 0;
        logic [31:0] exp_ld, obs_ld;
        e = model(v, ld, st, sb, sh, alu, data, g, r);
        exp_ld = e.upd ? rd : model_ld;
        obs_ld = '0;
        valid_MEM = v; ld_MEM = ld; st_en_MEM = st; SB_MEM = sb; SH_MEM = sh;
        alu_MEM = alu; outmux_fb_MEM = data;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            gnt_i = req_o ? (nreq == g) : 1'($urandom);
            if (granted && !req_o && wait_seen == r) begin
                rvalid_i = 1'b1; rdata_i = rd;
            end else if (granted && !req_o && wait_seen < r) begin
                rvalid_i = 1'b0; rdata_i = $urandom;
            end else begin
                rvalid_i = 1'($urandom); rdata_i = $urandom;
            end
            @(negedge clk_i);
            if (misaligned_o) nmis++;
            if (bus_err_o) nerr++;
            if (req_o) begin
                nreq++;
                checks++;
                if ({we_o, addr_o, be_o} !== {e.we, e.addr, e.be} || (e.we && wdata_o !== e.wdata)) begin
                    errors++;
                    $display("FAIL %s bus_fields: got we=%0b addr=%h be=%b wdata=%h, want we=%0b addr=%h be=%b wdata=%h",
                             tag, we_o, addr_o, be_o, wdata_o, e.we, e.addr, e.be, e.wdata);
                end
                if (gnt_i && !st) granted = 1;
            end else if (granted) begin
                wait_seen++;
            end
            if (stall_o) nstall++;
            else begin
                done = 1; obs_ld = ld_data_o;
            end
            @(posedge clk_i); #1;
        end
        gnt_i = 1'b0; rvalid_i = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s completion: still stalled after 64 cycles, want DONE", tag);
        end
        checks++;
        if (nstall !== e.stall) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d want %0d", tag, nstall, e.stall);
        end
        checks++;
        if (nreq !== e.reqs) begin
            errors++;
            $display("FAIL %s req_cycles: got %0d want %0d", tag, nreq, e.reqs);
        end
        checks++;
        if (nmis !== int'(e.mis) || nerr !== int'(e.err)) begin
            errors++;
            $display("FAIL %s pulses: got mis=%0d err=%0d want mis=%0d err=%0d", tag, nmis, nerr, e.mis, e.err);
        end
        checks++;
        if (obs_ld !== exp_ld) begin
            errors++;
            $display("FAIL %s ld_data: got %h want %h", tag, obs_ld, exp_ld);
        end
        model_ld = exp_ld;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({req_o, we_o, addr_o, wdata_o, be_o, ld_data_o, misaligned_o, bus_err_o, stall_o} !== '0) begin
            errors++;
            $display("FAIL reset_values: got req=%0b we=%0b addr=%h wdata=%h be=%b ld=%h mis=%0b err=%0b stall=%0b, want all 0",
                     req_o, we_o, addr_o, wdata_o, be_o, ld_data_o, misaligned_o, bus_err_o, stall_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_store_byte();
        do_access("sb_1003", 1, 0, 1, 1, 0, 32'h0000_1003, 32'h0000_00AB, 0, 0, '0);
    endtask

    task automatic test_load_word();
        do_access("lw_2000", 1, 1, 0, 0, 0, 32'h0000_2000, 32'h1234_5678, 2, 2, 32'hDEAD_BEEF);
    endtask

    task automatic test_misaligned();
        do_access("sh_0101", 1, 0, 1, 0, 1, 32'h0000_0101, 32'h0000_BEEF, 0, 0, '0);
        do_access("sb_0101", 1, 0, 1, 1, 0, 32'h0000_0101, 32'h0000_0042, 0, 0, '0);
        do_access("lw_2002", 1, 1, 0, 0, 0, 32'h0000_2002, '0, 0, 0, 32'h5555_AAAA);
        do_access("lh_2002", 1, 1, 0, 0, 1, 32'h0000_2002, '0, 1, 0, 32'h0BAD_F00D);
    endtask

    task automatic test_timeout();
        do_access("lw_norvalid", 1, 1, 0, 0, 0, 32'h0000_4000, '0, 1, 1000, 32'h7777_7777);
        do_access("sw_nognt", 1, 0, 1, 0, 0, 32'h0000_4004, 32'h0101_0101, 1000, 0, '0);
    endtask

    task automatic test_reset_mid();
        valid_MEM = 1; ld_MEM = 1; st_en_MEM = 0; SB_MEM = 0; SH_MEM = 0;
        alu_MEM = 32'h0000_3000; gnt_i = 0; rvalid_i = 0;
        @(negedge clk_i);
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_idle_stall: got %0b want 1", stall_o);
        end
        @(posedge clk_i); #1; gnt_i = 1;
        @(negedge clk_i);
        checks++;
        if (req_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_req: got %0b want 1", req_o);
        end
        @(posedge clk_i); #1; gnt_i = 0; rst_i = 1;
        @(negedge clk_i);
        checks++;
        if (req_o !== 1'b0 || stall_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_wait: got req=%0b stall=%0b want req=0 stall=1", req_o, stall_o);
        end
        @(posedge clk_i); #1; rst_i = 0; valid_MEM = 0; rvalid_i = 1; rdata_i = 32'hCAFE_F00D;
        @(negedge clk_i);
        checks++;
        if (req_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_after: got req=%0b stall=%0b want req=0 stall=0", req_o, stall_o);
        end
        @(posedge clk_i); #1; rvalid_i = 0;
        model_ld = '0;
        @(negedge clk_i);
        checks++;
        if (ld_data_o !== model_ld || req_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_late_rvalid: got ld=%h req=%0b want ld=%h req=0", ld_data_o, req_o, model_ld);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            do_access("bubble_ld", 0, 1, 0, 0, 0, 32'h0000_5000, '0, 0, 0, 32'hFFFF_FFFF);
        end
        do_access("b2b_sw", 1, 0, 1, 0, 0, 32'h0000_6000, 32'h89AB_CDEF, 0, 0, '0);
        do_access("b2b_lw", 1, 1, 0, 0, 0, 32'h0000_6000, '0, 0, 0, 32'h89AB_CDEF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit v, ld, st, sb, sh;
            int sel, g, r;
            logic [31:0] alu;
            v   = ($urandom % 5) != 0;
            ld  = 1'($urandom);
            st  = 1'($urandom);
            sel = $urandom % 3;
            sb  = (sel == 1);
            sh  = (sel == 2);
            alu = $urandom;
            if ($urandom % 2 == 0) alu[1:0] = 2'b00;
            g   = ($urandom % 8 == 0) ? 20 : int'($urandom % 5);
            r   = ($urandom % 8 == 0) ? 20 : int'($urandom % 3);
            do_access("random", v, ld, st, sb, sh, alu, $urandom, g, r, $urandom);
        end
    endtask

    task automatic test_idle_tail();
        valid_MEM = 0;
        repeat (2) begin
            @(negedge clk_i);
            checks++;
            if ({req_o, stall_o, misaligned_o, bus_err_o} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_tail: got req=%0b stall=%0b mis=%0b err=%0b want all 0",
                         req_o, stall_o, misaligned_o, bus_err_o);
            end
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        rst_i = 1; valid_MEM = 0; ld_MEM = 0; st_en_MEM = 0; SB_MEM = 0; SH_MEM = 0;
        alu_MEM = '0; outmux_fb_MEM = '0; gnt_i = 0; rvalid_i = 0; rdata_i = '0;
        @(posedge clk_i); #1;
        test_reset();
        test_store_byte();
        test_load_word();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_idle_tail();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the MEM stage of the 5-stage pipeline. It takes the load/store operation held in the EX/MEM pipeline register and drives a request/grant/response data-memory bus. It generates byte enables and replicated store data from the SB/SH flags. It stalls the whole pipeline until the access completes, and flags misaligned accesses and bus timeouts.

## Interface
- Width, 32, data/address width (byte-lane logic fixed to 4 lanes).
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is abandoned.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_MEM  in  1  EX/MEM register holds a real (non-bubble) instruction.
- ld_MEM  in  1  instruction is a load.
- st_en_MEM  in  1  instruction is a store.
- SB_MEM, SH_MEM  in  1 each  byte / halfword access; neither set = word.
- alu_MEM  in  Width  effective address.
- outmux_fb_MEM  in  Width  store data (low bits significant).
- req_o  out  1  bus request.
- we_o  out  1  write enable, meaningful while req_o.
- addr_o  out  Width  word-aligned address ({alu_MEM[Width-1:2],2'b00}).
- wdata_o  out  Width  lane-replicated store data.
- be_o  out  4  byte enables.
- gnt_i  in  1  bus accepts request this cycle.
- rvalid_i  in  1  read data valid.
- rdata_i  in  Width  read data.
- ld_data_o  out  Width  captured raw load word for writeback.
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; insert bubble into MEM/WB.
- misaligned_o  out  1  one-cycle exception pulse.
- bus_err_o  out  1  one-cycle timeout pulse.

## Operation
- mem_op = valid_MEM & (ld_MEM | st_en_MEM). If both ld_MEM and st_en_MEM are set, the access is a store.
- Misaligned: SH with alu_MEM[0]=1; word with alu_MEM[1:0]≠0. SB is never misaligned.
- Byte enables: SB → 4'b0001<<alu_MEM[1:0]; SH → 4'b0011<<{alu_MEM[1],1'b0}; word → 4'b1111.
- Store data: SB → byte [7:0] replicated ×4; SH → half [15:0] replicated ×2; word → unchanged.
- States: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - mem_op and aligned → capture addr/we/be/wdata into output registers, clear timeout counter, go to REQ.
  - mem_op and misaligned → go to DONE with the misaligned flag set; no bus request.
  - Otherwise stay in IDLE.
- REQ: req_o=1, outputs held stable.
  - gnt_i and store → DONE.
  - gnt_i and load → WAIT.
- WAIT: req_o=0. rvalid_i → capture rdata_i into ld_data_o, go to DONE.
- Timeout: the counter increments every cycle in REQ or WAIT. When it reaches TIMEOUT without gnt_i/rvalid_i, go to DONE with bus_err set.
- DONE: misaligned_o / bus_err_o asserted if flagged; next state IDLE.
- stall_o = mem_op & (state≠DONE). stall_o is combinational, so the pipeline advances exactly in the DONE cycle.
- ld_data_o holds its value until the next rvalid capture. On timeout or misalignment it is not updated.
- rvalid_i outside WAIT and gnt_i outside REQ are ignored.

## Timing
- Reset values: state IDLE, req_o 0, we_o 0, addr_o 0, wdata_o 0, be_o 0, ld_data_o 0, misaligned_o 0, bus_err_o 0, counter 0.
- Reset mid-transaction: next cycle is IDLE with req_o=0, the outstanding access is dropped, and stall_o follows mem_op.
- req_o is registered and rises one cycle after the op appears in MEM.
- Zero-wait store: c0 IDLE (stall 1), c1 REQ+gnt (stall 1), c2 DONE (stall 0). That is 2 stall cycles.
- Zero-wait load (rvalid one cycle after gnt): c0 IDLE, c1 REQ+gnt, c2 WAIT+rvalid, c3 DONE. That is 3 stall cycles, and ld_data_o is valid in c3.
- Misaligned access: c0 IDLE, c1 DONE with misaligned_o=1. That is 1 stall cycle.
- Back-to-back memory ops: after DONE, the next op is evaluated in IDLE the following cycle. There are no idle bus cycles beyond that.
- Non-memory instructions: stall_o=0 and the FSM stays in IDLE.
- Timeout: bus_err_o pulses in the DONE cycle following the TIMEOUT-th cycle in REQ+WAIT.

## Test plan
- SB, alu_MEM=0x1003, data 0xAB, gnt in first REQ cycle → be_o=4'b1000, wdata_o=0xABABABAB, addr_o=0x1000, we_o=1, stall_o high for 2 cycles.
- LW at 0x2000, gnt after 2 cycles, rvalid 3 cycles later, rdata 0xDEADBEEF → req_o held stable throughout, ld_data_o=0xDEADBEEF in DONE, stall_o high for 7 cycles.
- SH at 0x0101 → no req_o, misaligned_o=1 for exactly one cycle, stall_o high for 1 cycle; SB at 0x0101 proceeds normally.
- LW, gnt given but rvalid never arrives, TIMEOUT=8 → bus_err_o pulses once, FSM returns to IDLE, ld_data_o unchanged.
- rst_i asserted in WAIT → req_o=0 and state IDLE next cycle; a late rvalid_i does not change ld_data_o.
- Bubble (valid_MEM=0) carrying ld_MEM=1, followed by back-to-back SW, LW → bubble causes no request and no stall; both accesses complete in order with correct stall counts.
